// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: the hex/segment table (used by both encoder and decoder),
// the stability FSM encoding and the legal single-digit anode patterns.
package sseg_pkg;

    // Active-low {a,b,c,d,e,f,g} pattern for each hex digit, indexed by value.
    localparam logic [0:15][6:0] SEG_TABLE = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        StWait  = 2'd0,
        StCount = 2'd1,
        StHold  = 2'd2
    } sseg_state_e;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

    function automatic logic an_valid(input logic [3:0] an);
        return (an == AN_DIG0) || (an == AN_DIG1) || (an == AN_DIG2) || (an == AN_DIG3);
    endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
// Unrecognised patterns decode to 0 with err_o set.
module sseg_to_hex
    import sseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] hex_o,
    output logic       err_o
);

    always_comb begin
        hex_o = 4'h0;
        err_o = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_TABLE[i]) begin
                hex_o = 4'(i);
                err_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sseg_mux_decoder.sv
// Reconstructs four hex digits and decimal points from a multiplexed anode/segment bus,
// capturing each digit once per stable dwell and pulsing frame_done when all four are seen.
module sseg_mux_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [15:0] hex_out,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic        frame_done
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W:0] STABLE_LIM = (CNT_W + 1)'(STABLE_CYCLES);

    logic [3:0]       s_an_q, prev_an_q;
    logic [7:0]       s_sseg_q, prev_sseg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_next;
    sseg_state_e      state_q, state_d;
    logic             pair_valid, pair_changed, capture;

    logic [3:0][3:0]  nib_q, nib_d;
    logic [3:0]       dp_q, dp_d, err_q, err_d, vld_q, vld_d, mask_new;
    logic             frame_q, frame_d;
    logic [1:0]       idx;
    logic [3:0]       dec_hex;
    logic             dec_err;

    sseg_to_hex u_dec (
        .seg_i (s_sseg_q[6:0]),
        .hex_o (dec_hex),
        .err_o (dec_err)
    );

    assign pair_valid   = an_valid(s_an_q);
    assign pair_changed = {s_an_q, s_sseg_q} != {prev_an_q, prev_sseg_q};
    assign cnt_next     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Count starts the cycle after a change, so STABLE_CYCLES identical samples
    // need STABLE_CYCLES+1 identical pin values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (!pair_valid) begin
            state_d = StWait;
            cnt_d   = '0;
        end else if (pair_changed) begin
            state_d = StCount;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StWait: begin
                    state_d = StCount;
                    cnt_d   = '0;
                end
                StCount: begin
                    if (cnt_next >= STABLE_LIM) begin
                        capture = 1'b1;
                        state_d = StHold;
                    end else begin
                        cnt_d = cnt_next[CNT_W-1:0];
                    end
                end
                default: state_d = StHold;
            endcase
        end
    end

    always_comb begin
        case (s_an_q)
            AN_DIG1: idx = 2'd1;
            AN_DIG2: idx = 2'd2;
            AN_DIG3: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        nib_d    = nib_q;
        dp_d     = dp_q;
        err_d    = err_q;
        vld_d    = vld_q;
        frame_d  = 1'b0;
        mask_new = vld_q | (4'b0001 << idx);
        if (capture) begin
            nib_d[idx] = dec_hex;
            dp_d[idx]  = s_sseg_q[7];
            err_d[idx] = dec_err;
            // A completed frame restarts the mask instead of ever showing 1111.
            if (mask_new == 4'hF) begin
                vld_d   = 4'h0;
                frame_d = 1'b1;
            end else begin
                vld_d = mask_new;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_an_q      <= 4'hF;
            s_sseg_q    <= 8'hFF;
            prev_an_q   <= 4'hF;
            prev_sseg_q <= 8'hFF;
            cnt_q       <= '0;
            state_q     <= StWait;
            nib_q       <= '0;
            dp_q        <= 4'h0;
            err_q       <= 4'h0;
            vld_q       <= 4'h0;
            frame_q     <= 1'b0;
        end else begin
            s_an_q      <= an;
            s_sseg_q    <= sseg;
            prev_an_q   <= s_an_q;
            prev_sseg_q <= s_sseg_q;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            nib_q       <= nib_d;
            dp_q        <= dp_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
            frame_q     <= frame_d;
        end
    end

    assign hex_out     = nib_q;
    assign dp_out      = dp_q;
    assign digit_valid = vld_q;
    assign digit_err   = err_q;
    assign frame_done  = frame_q;

endmodule

// File: doc/sseg_mux_decoder.md
Name: sseg_mux_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment path and the four-digit time-multiplexed display driver.
- Observes a multiplexed anode/segment bus (an, sseg), as driven to the board display, and reconstructs the four hex digits and decimal points.
- Used as an on-chip monitor and scoreboard source for display logic, and to read back seven-segment data from external sources.

Parameters:
- STABLE_CYCLES, 4: consecutive sampling edges an/sseg must hold an identical valid value before capture. Legal range 1..255.
- CNT_W, 8: stability counter width. Localparam; not overridable.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- an, input, 4: anode enables, active low; exactly one low bit selects the digit (an[i]=0 selects digit i).
- sseg, input, 8: sseg[7] is the dp bit, passed raw. sseg[6:0] is {a,b,c,d,e,f,g}, active low.
- hex_out, output, 16: decoded digits; digit i is in hex_out[4i+3:4i].
- dp_out, output, 4: raw dp bit captured per digit.
- digit_valid, output, 4: digit captured since the last frame_done.
- digit_err, output, 4: last capture of digit i held an unrecognised segment pattern.
- frame_done, output, 1: one-cycle pulse when all four digits have been captured.

Behaviour:
- **Input stage.** an and sseg are registered once (s_an, s_sseg); they are not resynchronised, and external asynchronous use needs an upstream synchroniser. A pair is valid when s_an has exactly one zero bit (1110, 1101, 1011, 0111). All-ones (blanking) and multi-low values are invalid.
- **FSM states.**
  - S_WAIT: pair invalid.
  - S_COUNT: pair valid, stability counting.
  - S_HOLD: this dwell is already captured.
- **FSM transitions.**
  - Any change of {s_an,s_sseg} versus the previous cycle, or an invalid pair, forces the counter to 0. The next state is then S_COUNT if the new pair is valid, else S_WAIT.
  - In S_COUNT, the counter increments while the pair is unchanged.
  - When the pair has been identical for STABLE_CYCLES consecutive s_* samples, capture fires and the FSM enters S_HOLD.
  - S_HOLD stays until the pair changes or goes invalid, so exactly one capture happens per dwell.
- **Latency.** If the pins hold a constant valid value for edges k..k+STABLE_CYCLES, the outputs show the capture after edge k+STABLE_CYCLES+1. With STABLE_CYCLES=1, a value held across 2 edges is captured.
- **Decode table** (sseg[6:0], active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Any other pattern, including all-off 1111111, stores hex 0 and sets digit_err[i]=1. A good decode clears digit_err[i].
- **Capture of digit i.**
  - Writes hex_out nibble i, dp_out[i] = s_sseg[7], and digit_err[i].
  - Sets digit_valid[i].
  - Recapturing an already-valid digit overwrites its data; the mask is unchanged.
- **Frame completion.**
  - When a capture makes digit_valid equal 1111, frame_done=1 for exactly the cycle where the new mask would be 1111.
  - At that same edge digit_valid clears to 0000; the mask is never seen as 1111.
  - hex_out, dp_out and digit_err are not cleared.
- **Reset, at assertion regardless of clk.**
  - hex_out=0, dp_out=0, digit_valid=0, digit_err=0, frame_done=0.
  - FSM to S_WAIT, counter=0, s_an=4'hF, s_sseg=8'hFF.
  - Reset mid-dwell discards the partial count. After release, a full STABLE_CYCLES hold is required.
- **Counter.** Saturates, with no wrap; it cannot exceed STABLE_CYCLES because capture moves the FSM to S_HOLD.

Decomposition:
- Shared package (sseg_pkg):
  - the 16-entry segment pattern constants, shared with the hex-to-seven-segment encoder so both directions use one table;
  - the FSM state encoding (2-bit);
  - the valid-anode constants.
- One natural sub-module: sseg_to_hex, a combinational decode of 7 bits into {hex[3:0], err}, instanced once.
- Stability FSM, capture registers and frame mask stay in the top module.

Test Plan:
- **Reset.** Assert reset mid-dwell with an=1110, sseg=8'h01 held 2 cycles, STABLE_CYCLES=4 → all outputs 0 immediately. After release, capture occurs only after a full fresh hold.
- **Single capture.** an=1101, sseg=8'b1_0100100 held 10 cycles → hex_out[7:4]=5, dp_out[1]=1, digit_valid=0010, and exactly one capture, appearing 5 edges after the hold starts.
- **Full frame.** Scan digits 0..3 with patterns 0,7,A,F, 8 cycles each, with an=1111 blanking for 2 cycles between digits → hex_out=16'hFA70. frame_done pulses once after digit 3. digit_valid reads 0111 before the pulse and 0000 after.
- **Glitch rejection.** an=1011 with sseg changing every 2 cycles, or an=1001 held 20 cycles → no capture, digit_valid unchanged.
- **Invalid pattern.** an=0111, sseg=8'hFF held 6 cycles → hex_out[15:12]=0, digit_err[3]=1. A later capture of 8'h00 on the same digit → hex_out[15:12]=8, digit_err[3]=0.
- **Recapture.** Capture digit 0 as 3, then as 9, before the other digits → hex_out[3:0]=9, digit_valid=0001, no frame_done.
